// File: rtl/sobel_window_gen.sv
// Raster-scan pixel stream to 3x3 neighbourhood generator for the Sobel stage.
// Two line buffers hold the previous two rows; a 3x3 shift window emits one window per interior pixel.
module sobel_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] el1,
  output logic [PIX_W-1:0] el2,
  output logic [PIX_W-1:0] el3,
  output logic [PIX_W-1:0] el4,
  output logic [PIX_W-1:0] el5,
  output logic [PIX_W-1:0] el6,
  output logic [PIX_W-1:0] el7,
  output logic [PIX_W-1:0] el8,
  output logic [PIX_W-1:0] el9,
  output logic             flag,
  output logic             frame_done,
  output logic             busy
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t           state, state_nxt;
  logic [COL_W-1:0] col, eff_col;
  logic [ROW_W-1:0] row, eff_row;
  logic             accept, emit, last_col, last_row;
  logic [PIX_W-1:0] top, mid;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];

  // Window columns, index 0 = leftmost (c-2), index 2 = rightmost (c).
  logic [PIX_W-1:0] win_top [3];
  logic [PIX_W-1:0] win_mid [3];
  logic [PIX_W-1:0] win_bot [3];
  logic [PIX_W-1:0] nxt_top [3];
  logic [PIX_W-1:0] nxt_mid [3];
  logic [PIX_W-1:0] nxt_bot [3];

  // A valid sof restarts the frame: that pixel is (0,0) whatever the counters say.
  assign accept   = pix_valid && (sof || state != IDLE);
  assign eff_col  = sof ? '0 : col;
  assign eff_row  = sof ? '0 : row;
  assign last_col = (eff_col == COL_LAST);
  assign last_row = (eff_row == ROW_LAST);
  assign emit     = accept && (eff_row >= ROW_W'(2)) && (eff_col >= COL_W'(2));
  assign top      = lb1[eff_col];
  assign mid      = lb0[eff_col];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    // NOTE: default assignment first, so no path through this block infers a latch.
    state_nxt = state;
    if (accept) begin
      if (sof) begin
        state_nxt = FILL;
      end else begin
        unique case (state)
          FILL:    if (eff_row == ROW_W'(1) && last_col) state_nxt = STREAM;
          STREAM:  if (last_row && last_col)             state_nxt = IDLE;
          default: state_nxt = state;
        endcase
      end
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state != IDLE);
  end

  // ---------------- Next window: shift left, insert {top, mid, p} ----------------
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      nxt_top[k] = (eff_col == '0) ? '0 : win_top[k+1];
      nxt_mid[k] = (eff_col == '0) ? '0 : win_mid[k+1];
      nxt_bot[k] = (eff_col == '0) ? '0 : win_bot[k+1];
    end
    nxt_top[2] = top;
    nxt_mid[2] = mid;
    nxt_bot[2] = pix_in;
  end

  // ---------------- Line buffers ----------------
  // NOTE: line-buffer RAM is deliberately not reset; rows 0 and 1 of every frame rewrite it before any flagged read.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[eff_col] <= lb0[eff_col];
      lb0[eff_col] <= pix_in;
    end
  end

  // ---------------- Counters, window, outputs ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      flag       <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        win_top[k] <= '0;
        win_mid[k] <= '0;
        win_bot[k] <= '0;
      end
      {el1, el2, el3, el4, el5, el6, el7, el8, el9} <= '0;
    end else begin
      flag       <= emit;
      frame_done <= accept && !sof && (state == STREAM) && last_row && last_col;
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : eff_row + ROW_W'(1);
        end else begin
          col <= eff_col + COL_W'(1);
          row <= eff_row;
        end
        for (int k = 0; k < 3; k++) begin
          win_top[k] <= nxt_top[k];
          win_mid[k] <= nxt_mid[k];
          win_bot[k] <= nxt_bot[k];
        end
      end
      // Outputs only move when a window is presented; otherwise they hold.
      if (emit) begin
        {el1, el2, el3} <= {nxt_top[0], nxt_top[1], nxt_top[2]};
        {el4, el5, el6} <= {nxt_mid[0], nxt_mid[1], nxt_mid[2]};
        {el7, el8, el9} <= {nxt_bot[0], nxt_bot[1], nxt_bot[2]};
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 frame: plain, gapped, back-to-back,
// aborted and reset-interrupted frames, with windows collected on the falling edge.
module tb_sobel_window_gen;

  localparam int W = 5;
  localparam int H = 4;
  localparam int P = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sof = 1'b0;
  logic         pix_valid = 1'b0;
  logic [P-1:0] pix_in = '0;
  logic [P-1:0] el1, el2, el3, el4, el5, el6, el7, el8, el9;
  logic         flag, frame_done, busy;
  logic [71:0]  win_now;

  int n_checks = 0;
  int n_pass   = 0;

  logic [71:0] win_q[$];
  bit          fd_q[$];
  int          fd_count  = 0;
  int          gap_viol  = 0;
  int          busy_seen = 0;
  logic        v_prev    = 1'b0;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
    .el1(el1), .el2(el2), .el3(el3), .el4(el4), .el5(el5),
    .el6(el6), .el7(el7), .el8(el8), .el9(el9),
    .flag(flag), .frame_done(frame_done), .busy(busy)
  );

  assign win_now = {el1, el2, el3, el4, el5, el6, el7, el8, el9};

  always #5 clk = ~clk;

  // Inputs change 2 time units after posedge; the falling edge sees stable outputs and inputs.
  always @(negedge clk) begin
    if (flag) begin
      win_q.push_back(win_now);
      fd_q.push_back(frame_done);
      if (!v_prev) gap_viol++;
    end
    if (frame_done) fd_count++;
    if (busy) busy_seen++;
    v_prev = pix_valid;
  end

  function automatic logic [71:0] exp_win(input int base, input int r, input int c);
    logic [71:0] w = '0;
    for (int rr = r - 2; rr <= r; rr++)
      for (int cc = c - 2; cc <= c; cc++)
        w = {w[63:0], 8'(base + 10 * rr + cc)};
    return w;
  endfunction

  task automatic step(input logic v, input logic s, input logic [P-1:0] p);
    @(posedge clk);
    #2;
    pix_valid = v;
    sof       = s;
    pix_in    = p;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic clear_log();
    win_q.delete();
    fd_q.delete();
    fd_count  = 0;
    gap_viol  = 0;
    busy_seen = 0;
  endtask

  // Sends a frame in raster order; stops before (stop_r, stop_c) when stop_r >= 0.
  task automatic send_frame(input int base, input bit gaps, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (gaps)
          for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++)
            step(1'b0, 1'b0, 8'($urandom));
        step(1'b1, (r == 0 && c == 0), 8'(base + 10 * r + c));
      end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #3;
    n_checks++; if (flag !== 1'b0) $display("FAIL reset_flag: got %b expected 0", flag); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", frame_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (win_now !== 72'h0) $display("FAIL reset_el: got %h expected 0", win_now); else n_pass++;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_idle_ignore();
    clear_log();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i + 1));
    flush(3);
    n_checks++; if (win_q.size() !== 0) $display("FAIL idle_flags: got %0d expected 0", win_q.size()); else n_pass++;
    n_checks++; if (busy_seen !== 0) $display("FAIL idle_busy: got %0d busy cycles expected 0", busy_seen); else n_pass++;
  endtask

  task automatic test_basic();
    clear_log();
    send_frame(0, 1'b0, -1, -1);
    flush(3);
    n_checks++; if (win_q.size() !== 6) $display("FAIL basic_count: got %0d expected 6", win_q.size()); else n_pass++;
    if (win_q.size() == 6) begin
      n_checks++; if (win_q[0] !== 72'h00_01_02_0a_0b_0c_14_15_16) $display("FAIL basic_first: got %h expected 0001020a0b0c141516", win_q[0]); else n_pass++;
      n_checks++; if (win_q[5] !== 72'h0c_0d_0e_16_17_18_20_21_22) $display("FAIL basic_last: got %h expected 0c0d0e161718202122", win_q[5]); else n_pass++;
      for (int i = 0; i < 6; i++) begin
        n_checks++; if (win_q[i] !== exp_win(0, 2 + i / 3, 2 + i % 3)) $display("FAIL basic_win%0d: got %h expected %h", i, win_q[i], exp_win(0, 2 + i / 3, 2 + i % 3)); else n_pass++;
      end
      n_checks++; if (fd_q[5] !== 1'b1) $display("FAIL basic_fd_with_last: got %b expected 1", fd_q[5]); else n_pass++;
    end
    n_checks++; if (fd_count !== 1) $display("FAIL basic_fd_count: got %0d expected 1", fd_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_gaps();
    clear_log();
    send_frame(0, 1'b1, -1, -1);
    flush(3);
    n_checks++; if (win_q.size() !== 6) $display("FAIL gaps_count: got %0d expected 6", win_q.size()); else n_pass++;
    if (win_q.size() == 6)
      for (int i = 0; i < 6; i++) begin
        n_checks++; if (win_q[i] !== exp_win(0, 2 + i / 3, 2 + i % 3)) $display("FAIL gaps_win%0d: got %h expected %h", i, win_q[i], exp_win(0, 2 + i / 3, 2 + i % 3)); else n_pass++;
      end
    n_checks++; if (gap_viol !== 0) $display("FAIL gaps_flag_after_gap: got %0d expected 0", gap_viol); else n_pass++;
    n_checks++; if (fd_count !== 1) $display("FAIL gaps_fd_count: got %0d expected 1", fd_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_frame(0, 1'b0, -1, -1);
    send_frame(100, 1'b0, -1, -1);
    flush(3);
    n_checks++; if (win_q.size() !== 12) $display("FAIL b2b_count: got %0d expected 12", win_q.size()); else n_pass++;
    if (win_q.size() == 12) begin
      n_checks++; if (win_q[6] !== 72'h64_65_66_6e_6f_70_78_79_7a) $display("FAIL b2b_f2_first: got %h expected 6465666e6f7078797a", win_q[6]); else n_pass++;
      for (int i = 0; i < 12; i++) begin
        n_checks++; if (win_q[i] !== exp_win((i < 6) ? 0 : 100, 2 + (i % 6) / 3, 2 + i % 3)) $display("FAIL b2b_win%0d: got %h expected %h", i, win_q[i], exp_win((i < 6) ? 0 : 100, 2 + (i % 6) / 3, 2 + i % 3)); else n_pass++;
      end
    end
    n_checks++; if (fd_count !== 2) $display("FAIL b2b_fd_count: got %0d expected 2", fd_count); else n_pass++;
  endtask

  task automatic test_abort();
    clear_log();
    send_frame(0, 1'b0, 2, 3);
    send_frame(50, 1'b0, -1, -1);
    flush(3);
    // Window from (2,2) of the aborted frame still issues, then six from the new frame.
    n_checks++; if (win_q.size() !== 7) $display("FAIL abort_count: got %0d expected 7", win_q.size()); else n_pass++;
    if (win_q.size() == 7) begin
      n_checks++; if (win_q[0] !== exp_win(0, 2, 2)) $display("FAIL abort_owed: got %h expected %h", win_q[0], exp_win(0, 2, 2)); else n_pass++;
      n_checks++; if (fd_q[0] !== 1'b0) $display("FAIL abort_no_fd: got %b expected 0", fd_q[0]); else n_pass++;
      for (int i = 0; i < 6; i++) begin
        n_checks++; if (win_q[i+1] !== exp_win(50, 2 + i / 3, 2 + i % 3)) $display("FAIL abort_win%0d: got %h expected %h", i, win_q[i+1], exp_win(50, 2 + i / 3, 2 + i % 3)); else n_pass++;
      end
      n_checks++; if (fd_q[6] !== 1'b1) $display("FAIL abort_fd_last: got %b expected 1", fd_q[6]); else n_pass++;
    end
    n_checks++; if (fd_count !== 1) $display("FAIL abort_fd_count: got %0d expected 1", fd_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_log();
    send_frame(0, 1'b0, 3, 1);
    @(posedge clk);
    #1 pix_valid = 1'b0;
    n_checks++; if (win_now !== exp_win(0, 2, 4)) $display("FAIL rstmid_el_before: got %h expected %h", win_now, exp_win(0, 2, 4)); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (flag !== 1'b0) $display("FAIL rstmid_flag: got %b expected 0", flag); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL rstmid_frame_done: got %b expected 0", frame_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (win_now !== 72'h0) $display("FAIL rstmid_el: got %h expected 0", win_now); else n_pass++;
    @(posedge clk);
    #2 rst = 1'b0;
    clear_log();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(200 + i));
    flush(3);
    n_checks++; if (win_q.size() !== 0 || busy_seen !== 0) $display("FAIL rstmid_ignore: got %0d flags %0d busy cycles expected 0 0", win_q.size(), busy_seen); else n_pass++;
    clear_log();
    send_frame(0, 1'b0, -1, -1);
    flush(3);
    n_checks++; if (win_q.size() !== 6) $display("FAIL rstmid_count: got %0d expected 6", win_q.size()); else n_pass++;
    if (win_q.size() == 6)
      for (int i = 0; i < 6; i++) begin
        n_checks++; if (win_q[i] !== exp_win(0, 2 + i / 3, 2 + i % 3)) $display("FAIL rstmid_win%0d: got %h expected %h", i, win_q[i], exp_win(0, 2 + i / 3, 2 + i % 3)); else n_pass++;
      end
    n_checks++; if (fd_count !== 1) $display("FAIL rstmid_fd_count: got %0d expected 1", fd_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
